// File: rtl/barrel_shifter_32.sv
// Registered 32-bit barrel shifter: logical left, logical right and arithmetic right by 0..31.
// A single right-shift log network serves all three ops; left shifts are mirrored around it.
module barrel_shifter_32 #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] shift_amt,
  input  logic               lsl,
  input  logic               lsr,
  input  logic               asr,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid
);

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  // Select priority lsl > lsr > asr; with nothing selected the amount is forced to
  // zero so the network passes the operand straight through.
  logic             any_sel;
  logic             left_sel;
  logic             asr_sel;
  logic             fill;
  logic [SHAMT_W-1:0] eff_amt;

  assign any_sel  = lsl | lsr | asr;
  assign left_sel = lsl;
  assign asr_sel  = ~lsl & ~lsr & asr;
  assign fill     = asr_sel & in[WIDTH-1];
  assign eff_amt  = any_sel ? shift_amt : '0;

  logic [WIDTH-1:0] stage [0:SHAMT_W];
  logic [WIDTH-1:0] result;

  assign stage[0] = left_sel ? bit_rev(in) : in;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int STEP = 1 << k;
    assign stage[k+1] = eff_amt[k]
                      ? {{STEP{fill}}, stage[k][WIDTH-1:STEP]}
                      : stage[k];
  end

  assign result = left_sel ? bit_rev(stage[SHAMT_W]) : stage[SHAMT_W];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; out keeps its value (clock enable) when in_valid is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= result;
    end
  end

endmodule

// File: tb/tb_barrel_shifter_32.sv
// Directed and random checks of barrel_shifter_32 against hand values and a behavioural model.
module tb_barrel_shifter_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in;
  logic [4:0]  shift_amt;
  logic        lsl, lsr, asr;
  logic [31:0] out;
  logic        out_valid;

  int vectors     = 0;
  int miscompares = 0;

  barrel_shifter_32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (in),
    .shift_amt (shift_amt),
    .lsl       (lsl),
    .lsr       (lsr),
    .asr       (asr),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] amt,
                       input logic l, input logic r, input logic a);
    in_valid  = v;
    in        = d;
    shift_amt = amt;
    lsl       = l;
    lsr       = r;
    asr       = a;
  endtask

  // Apply the current inputs for one edge and sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op_check(input string tag, input logic [31:0] d, input logic [4:0] amt,
                          input logic l, input logic r, input logic a,
                          input logic [31:0] exp);
    drive(1'b1, d, amt, l, r, a);
    step();
    check({tag, "_out"}, out, exp);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'h1);
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] amt,
                                            input logic l, input logic r, input logic a);
    logic signed [31:0] s;
    s = d;
    if (l)      return d << amt;
    else if (r) return d >> amt;
    else if (a) return s >>> amt;
    else        return d;
  endfunction

  initial begin
    logic [31:0] exp_out;
    logic        exp_valid;
    logic [31:0] rd;
    logic [4:0]  ra;
    logic        rv, rl, rr, rs;

    // Reset wins over a valid operation presented on the same edge.
    rst_n = 1'b0;
    drive(1'b1, 32'hA5A5A5A5, 5'd2, 1'b1, 1'b0, 1'b0);
    step();
    check("reset_out", out, 32'h0);
    check("reset_valid", {31'b0, out_valid}, 32'h0);
    rst_n = 1'b1;

    op_check("lsl2", 32'hA5A5A5A5, 5'd2, 1'b1, 1'b0, 1'b0, 32'h96969694);
    op_check("lsr2", 32'hA5A5A5A5, 5'd2, 1'b0, 1'b1, 1'b0, 32'h29696969);
    op_check("asr2_neg", 32'hA5A5A5A5, 5'd2, 1'b0, 1'b0, 1'b1, 32'hE9696969);
    op_check("asr2_pos", 32'h25A5A5A5, 5'd2, 1'b0, 1'b0, 1'b1, 32'h09696969);

    op_check("lsl0", 32'h12345678, 5'd0, 1'b1, 1'b0, 1'b0, 32'h12345678);
    op_check("lsr0", 32'h87654321, 5'd0, 1'b0, 1'b1, 1'b0, 32'h87654321);
    op_check("asr0", 32'hF00DCAFE, 5'd0, 1'b0, 1'b0, 1'b1, 32'hF00DCAFE);
    op_check("asr31", 32'h80000000, 5'd31, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
    op_check("lsr31", 32'h80000000, 5'd31, 1'b0, 1'b1, 1'b0, 32'h00000001);
    op_check("lsl31", 32'h00000001, 5'd31, 1'b1, 1'b0, 1'b0, 32'h80000000);
    op_check("asr31_pos", 32'h7FFFFFFF, 5'd31, 1'b0, 1'b0, 1'b1, 32'h00000000);
    op_check("lsl16", 32'h0000BEEF, 5'd16, 1'b1, 1'b0, 1'b0, 32'hBEEF0000);
    op_check("asr7", 32'h80000000, 5'd7, 1'b0, 1'b0, 1'b1, 32'hFF000000);

    op_check("prio_all", 32'hA5A5A5A5, 5'd2, 1'b1, 1'b1, 1'b1, 32'h96969694);
    op_check("prio_lsr_asr", 32'hA5A5A5A5, 5'd2, 1'b0, 1'b1, 1'b1, 32'h29696969);
    op_check("none_sel", 32'hA5A5A5A5, 5'd2, 1'b0, 1'b0, 1'b0, 32'hA5A5A5A5);

    // Invalid input: out holds the last result, out_valid drops.
    drive(1'b0, 32'hDEADBEEF, 5'd4, 1'b1, 1'b0, 1'b0);
    step();
    check("hold_out", out, 32'hA5A5A5A5);
    check("hold_valid", {31'b0, out_valid}, 32'h0);
    step();
    check("hold_out2", out, 32'hA5A5A5A5);

    // Reset in mid-stream discards a valid operation.
    op_check("pre_reset", 32'h0000000F, 5'd4, 1'b1, 1'b0, 1'b0, 32'h000000F0);
    rst_n = 1'b0;
    drive(1'b1, 32'hFFFFFFFF, 5'd1, 1'b0, 1'b1, 1'b0);
    step();
    check("midreset_out", out, 32'h0);
    check("midreset_valid", {31'b0, out_valid}, 32'h0);
    rst_n = 1'b1;

    // Random stream against the behavioural model.
    exp_out   = 32'h0;
    exp_valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      rd = $urandom;
      ra = 5'($urandom_range(0, 31));
      rv = ($urandom_range(0, 9) != 0);
      rl = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 1) == 0);
      drive(rv, rd, ra, rl, rr, rs);
      if (rv) exp_out = ref_shift(rd, ra, rl, rr, rs);
      exp_valid = rv;
      step();
      check($sformatf("rand%0d_out", i), out, exp_out);
      check($sformatf("rand%0d_valid", i), {31'b0, out_valid}, {31'b0, exp_valid});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
